// File: rtl/cpu_pkg.sv
// Shared core types: data width, register address width, x0 constant
// and the register-file write request bundle.
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] X0_ADDR = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } rf_wr_req_t;

  function automatic logic is_x0(
    input logic [REG_ADDR_W-1:0] a
  );
    return a == X0_ADDR;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, power-of-two DEPTH, show-ahead head (rdata).
// Ports: clk, rst (async high), push/wdata, pop/rdata, full, empty, count.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             push_ok;
  logic             pop_ok;

  assign full    = cnt == CW'(DEPTH);
  assign empty   = cnt == '0;
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers wrap naturally: DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; contents are meaningless once cnt is 0.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port owner: pipeline writeback (P) beats the
// buffered long-latency return channel (L); tracks busy registers.
// Ports: clk, rst (async high); p_we/p_addr/p_data; l_valid/l_ready/
// l_addr/l_data; alloc_valid/alloc_rd; q_rs1/q_rs2/q_rd -> busy_*;
// drain_stall_req; rf_write_en/rf_write_addr/rf_write_data.
// Build option RF_WR_BYPASS_EN: an L result arriving at an empty FIFO
// with P idle is written straight through in the same cycle.
module rf_write_arbiter
  import cpu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NUM_REGS   = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p_we,
  input  logic [REG_ADDR_W-1:0] p_addr,
  input  logic [XLEN-1:0]       p_data,
  input  logic                  l_valid,
  output logic                  l_ready,
  input  logic [REG_ADDR_W-1:0] l_addr,
  input  logic [XLEN-1:0]       l_data,
  input  logic                  alloc_valid,
  input  logic [REG_ADDR_W-1:0] alloc_rd,
  input  logic [REG_ADDR_W-1:0] q_rs1,
  input  logic [REG_ADDR_W-1:0] q_rs2,
  input  logic [REG_ADDR_W-1:0] q_rd,
  output logic                  busy_rs1,
  output logic                  busy_rs2,
  output logic                  busy_rd,
  output logic                  drain_stall_req,
  output logic                  rf_write_en,
  output logic [REG_ADDR_W-1:0] rf_write_addr,
  output logic [XLEN-1:0]       rf_write_data
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } ent_t;

  ent_t              push_ent;
  ent_t              head;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [CW-1:0]     cnt;
  logic              p_win;
  logic              head_x0;
  logic              drain;
  logic              byp;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [SW-1:0]     starve;

  assign p_win   = !rst && p_we && !is_x0(p_addr);
  assign l_ready = !rst && !full;
  assign head_x0 = is_x0(head.addr);

  // An x0 head needs no write port, so it retires even under a P write.
  assign pop   = !rst && !empty && (!p_win || head_x0);
  assign drain = pop && !p_win;

`ifdef RF_WR_BYPASS_EN
  assign byp = !rst && empty && !p_win && l_valid;
`else
  assign byp = 1'b0;
`endif

  assign push     = l_valid && l_ready && !byp;
  assign push_ent = '{addr: l_addr, data: l_data};

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(ent_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_ent),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (cnt)
  );

  always_comb begin
    rf_write_en   = 1'b0;
    rf_write_addr = p_addr;
    rf_write_data = p_data;
    unique case (1'b1)
      p_win: begin
        rf_write_en = 1'b1;
      end
      drain: begin
        rf_write_en   = !head_x0;
        rf_write_addr = head.addr;
        rf_write_data = head.data;
      end
      byp: begin
        rf_write_en   = !is_x0(l_addr);
        rf_write_addr = l_addr;
        rf_write_data = l_data;
      end
      default: begin
        rf_write_en = 1'b0;
      end
    endcase
  end

  // Clears first, then set: a same-cycle alloc of a retiring rd wins.
  always_comb begin
    busy_nxt = busy;
    if (pop)
      busy_nxt[head.addr] = 1'b0;
    if (byp)
      busy_nxt[l_addr] = 1'b0;
    if (alloc_valid && !is_x0(alloc_rd))
      busy_nxt[alloc_rd] = 1'b1;
    busy_nxt[X0_ADDR] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy            <= '0;
      starve          <= '0;
      drain_stall_req <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (cnt != '0 && p_win && !pop) begin
        if (starve == SW'(STARVE_MAX - 1)) begin
          starve          <= '0;
          drain_stall_req <= 1'b1;
        end else begin
          starve          <= starve + 1'b1;
          drain_stall_req <= 1'b0;
        end
      end else begin
        starve          <= '0;
        drain_stall_req <= 1'b0;
      end
    end
  end

  assign busy_rs1 = !is_x0(q_rs1) && busy[q_rs1];
  assign busy_rs2 = !is_x0(q_rs2) && busy[q_rs2];
  assign busy_rd  = !is_x0(q_rd) && busy[q_rd];

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed and random stimulus for rf_write_arbiter, checked against a
// queue/array reference model of the register-file write port.
module tb_rf_write_arbiter;

  localparam int DEPTH = 4;
  localparam int SMAX  = 8;
`ifdef RF_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        p_we;
  logic [4:0]  p_addr;
  logic [31:0] p_data;
  logic        l_valid;
  logic        l_ready;
  logic [4:0]  l_addr;
  logic [31:0] l_data;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic [4:0]  q_rs1;
  logic [4:0]  q_rs2;
  logic [4:0]  q_rd;
  logic        busy_rs1;
  logic        busy_rs2;
  logic        busy_rd;
  logic        drain_stall_req;
  logic        rf_write_en;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;

  rf_write_arbiter #(
    .XLEN       (32),
    .NUM_REGS   (32),
    .FIFO_DEPTH (DEPTH),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .p_we            (p_we),
    .p_addr          (p_addr),
    .p_data          (p_data),
    .l_valid         (l_valid),
    .l_ready         (l_ready),
    .l_addr          (l_addr),
    .l_data          (l_data),
    .alloc_valid     (alloc_valid),
    .alloc_rd        (alloc_rd),
    .q_rs1           (q_rs1),
    .q_rs2           (q_rs2),
    .q_rd            (q_rd),
    .busy_rs1        (busy_rs1),
    .busy_rs2        (busy_rs2),
    .busy_rd         (busy_rd),
    .drain_stall_req (drain_stall_req),
    .rf_write_en     (rf_write_en),
    .rf_write_addr   (rf_write_addr),
    .rf_write_data   (rf_write_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t mq[$];
  bit   mbusy[32];
  int   mstarve;
  bit   mreq;
  bit   hold;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    p_we        = 1'b0;
    p_addr      = 5'd0;
    p_data      = 32'd0;
    l_valid     = 1'b0;
    l_addr      = 5'd0;
    l_data      = 32'd0;
    alloc_valid = 1'b0;
    alloc_rd    = 5'd0;
  endtask

  // Called just after a falling edge with inputs applied: checks this
  // cycle's outputs, advances the model, waits for the next falling edge.
  task automatic step();
    bit          pwin;
    bit          pop;
    bit          byp;
    bit          full;
    bit          en;
    logic [4:0]  ea;
    logic [31:0] ed;
    #1;
    if (rst) begin
      mq.delete();
      foreach (mbusy[i]) mbusy[i] = 1'b0;
      mstarve = 0;
      mreq    = 1'b0;
    end
    full = mq.size() == DEPTH;
    pwin = !rst && p_we && p_addr != 5'd0;
    byp  = BYP && !rst && mq.size() == 0 && !pwin && l_valid;
    pop  = !rst && mq.size() > 0 && (!pwin || mq[0].a == 5'd0);
    en = 1'b0;
    ea = 5'd0;
    ed = 32'd0;
    if (pwin) begin
      en = 1'b1;
      ea = p_addr;
      ed = p_data;
    end else if (pop) begin
      en = mq[0].a != 5'd0;
      ea = mq[0].a;
      ed = mq[0].d;
    end else if (byp) begin
      en = l_addr != 5'd0;
      ea = l_addr;
      ed = l_data;
    end
    chk("rf_write_en", rf_write_en, en);
    if (en) begin
      chk("rf_write_addr", rf_write_addr, ea);
      chk("rf_write_data", rf_write_data, ed);
    end
    chk("l_ready", l_ready, !rst && !full);
    chk("busy_rs1", busy_rs1, q_rs1 != 5'd0 && mbusy[q_rs1]);
    chk("busy_rs2", busy_rs2, q_rs2 != 5'd0 && mbusy[q_rs2]);
    chk("busy_rd", busy_rd, q_rd != 5'd0 && mbusy[q_rd]);
    chk("drain_stall_req", drain_stall_req, mreq);
    hold = !rst && l_valid && full;
    if (!rst) begin
      if (mq.size() > 0 && pwin && !pop) begin
        mstarve++;
        mreq = mstarve == SMAX;
        if (mreq) mstarve = 0;
      end else begin
        mstarve = 0;
        mreq    = 1'b0;
      end
      if (pop) begin
        mbusy[mq[0].a] = 1'b0;
        void'(mq.pop_front());
      end
      if (byp)
        mbusy[l_addr] = 1'b0;
      if (l_valid && !full && !byp)
        mq.push_back('{l_addr, l_data});
      if (alloc_valid && alloc_rd != 5'd0)
        mbusy[alloc_rd] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int phase;
    idle();
    q_rs1 = 5'd0;
    q_rs2 = 5'd0;
    q_rd  = 5'd0;
    hold  = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    step();
    rst = 1'b0;
    step();

    // P and L collide: P first, L one cycle later.
    alloc_valid = 1'b1;
    alloc_rd    = 5'd7;
    step();
    alloc_valid = 1'b0;
    p_we = 1'b1; p_addr = 5'd3; p_data = 32'hAAAA;
    l_valid = 1'b1; l_addr = 5'd7; l_data = 32'h1234;
    q_rd = 5'd7;
    #1 chk("coll_p_addr", rf_write_addr, 5'd3);
    step();
    idle();
    #1 chk("coll_l_data", rf_write_data, 32'h1234);
    chk("coll_busy7_held", busy_rd, 1'b1);
    step();
    #1 chk("coll_busy7_clear", busy_rd, 1'b0);
    step();

    // Fill the FIFO under continuous P writes.
    p_we = 1'b1; p_addr = 5'd1; p_data = 32'h11;
    for (int i = 0; i < 5; i++) begin
      l_valid = 1'b1;
      l_addr  = 5'(10 + i);
      l_data  = 32'(100 + i);
      if (i == 4) #1 chk("full_l_ready", l_ready, 1'b0);
      step();
    end
    p_we = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (!hold) l_valid = 1'b0;
      step();
    end

    // Starvation: one queued entry, P busy for eight cycles.
    p_we = 1'b1; p_addr = 5'd2; p_data = 32'h22;
    l_valid = 1'b1; l_addr = 5'd10; l_data = 32'hCAFE;
    alloc_valid = 1'b1; alloc_rd = 5'd10;
    step();
    l_valid = 1'b0;
    alloc_valid = 1'b0;
    repeat (SMAX) step();
    p_we = 1'b0;
    #1 chk("starve_req", drain_stall_req, 1'b1);
    chk("starve_drain_addr", rf_write_addr, 5'd10);
    step();
    #1 chk("starve_req_drop", drain_stall_req, 1'b0);
    step();

    // Alloc races a pop of the same rd; x0 entry retires silently.
    p_we = 1'b1; p_addr = 5'd1; p_data = 32'h1;
    l_valid = 1'b1; l_addr = 5'd9; l_data = 32'h99;
    alloc_valid = 1'b1; alloc_rd = 5'd9;
    step();
    p_we = 1'b0;
    l_addr = 5'd0; l_data = 32'h5;
    q_rd = 5'd9;
    #1 chk("race_pop_addr", rf_write_addr, 5'd9);
    step();
    idle();
    p_we = 1'b1; p_addr = 5'd2; p_data = 32'h22;
    #1 chk("race_busy9", busy_rd, 1'b1);
    chk("x0_p_write_addr", rf_write_addr, 5'd2);
    step();
    idle();
    #1 chk("x0_gone", rf_write_en, 1'b0);
    step();

    // L into an empty FIFO with P idle.
    l_valid = 1'b1; l_addr = 5'd4; l_data = 32'h55;
    #1 chk("byp_same_cycle", rf_write_en, BYP);
    step();
    idle();
    #1 chk("byp_next_cycle", rf_write_en, !BYP);
    step();

    // Reset with two entries queued and x5 busy.
    p_we = 1'b1; p_addr = 5'd1; p_data = 32'h1;
    l_valid = 1'b1; l_addr = 5'd5; l_data = 32'h50;
    alloc_valid = 1'b1; alloc_rd = 5'd5;
    step();
    alloc_valid = 1'b0;
    l_addr = 5'd6; l_data = 32'h60;
    step();
    rst = 1'b1;
    q_rd = 5'd5;
    #1 chk("rst_write_en", rf_write_en, 1'b0);
    chk("rst_l_ready", l_ready, 1'b0);
    chk("rst_busy5", busy_rd, 1'b0);
    step();
    rst = 1'b0;
    idle();
    #1 chk("rst_rel_ready", l_ready, 1'b1);
    chk("rst_rel_empty", rf_write_en, 1'b0);
    step();

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      phase = (n / 150) % 2;
      if (rst) begin
        rst = 1'b0;
        idle();
      end else if ($urandom_range(0, 249) == 0) begin
        rst = 1'b1;
      end else begin
        p_we = phase == 1 ? ($urandom_range(0, 9) < 9)
                          : ($urandom_range(0, 9) < 4);
        p_addr = $urandom_range(0, 7) == 0 ? 5'd0
                                           : 5'($urandom_range(1, 31));
        p_data = $urandom;
        if (!hold) begin
          l_valid = $urandom_range(0, 2) == 0;
          l_addr  = 5'($urandom_range(0, 31));
          l_data  = $urandom;
        end
        alloc_valid = $urandom_range(0, 3) == 0;
        alloc_rd    = 5'($urandom_range(0, 31));
      end
      q_rs1 = 5'($urandom_range(0, 31));
      q_rs2 = 5'($urandom_range(0, 31));
      q_rd  = 5'($urandom_range(0, 31));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Owns the register file's single write port.
- Arbitrates between the in-order pipeline writeback (port P) and a long-latency return channel (port L), e.g. shared-memory load returns in the multicore build.
- Buffers port-L results in a small FIFO.
- Keeps a busy scoreboard of registers with outstanding long-latency writes, so decode can stall on RAW/WAW.
- Drives the register file's write_addr/write_data/write_enable directly, in place of the raw writeback signals.

Parameters:
XLEN, 32, data width
NUM_REGS, 32, architectural registers (address width = log2(NUM_REGS))
FIFO_DEPTH, 4, port-L buffer entries; power of two, >= 2
STARVE_MAX, 8, consecutive blocked cycles before a forced drain is requested

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
p_we  input  1  pipeline writeback enable
p_addr  input  5  pipeline writeback rd
p_data  input  XLEN  pipeline writeback data
l_valid  input  1  long-latency result valid
l_ready  output  1  FIFO can accept (not full)
l_addr  input  5  long-latency rd
l_data  input  XLEN  long-latency data
alloc_valid  input  1  long-latency op dispatched this cycle
alloc_rd  input  5  its destination register
q_rs1, q_rs2, q_rd  input  5 each  decode query addresses
busy_rs1, busy_rs2, busy_rd  output  1 each  combinational scoreboard hits (x0 always 0)
drain_stall_req  output  1  request to hazard logic: suppress p_we next cycle
rf_write_en  output  1  to register file
rf_write_addr  output  5  to register file
rf_write_data  output  XLEN  to register file

Behaviour:
- Reset (async):
  - FIFO pointers and count = 0; busy bitmap = 0; starvation counter = 0; drain_stall_req = 0.
  - While rst is high: rf_write_en = 0 and l_ready = 0.
- Port P has no backpressure and wins whenever p_we=1 and p_addr!=0.
  - rf_* = p_*, combinational, zero latency.
- Port L handshake:
  - Push occurs on l_valid && l_ready; l_ready = !full.
  - Data is held stable by the sender while l_valid && !l_ready.
- FIFO drain: when port P is not writing and FIFO is non-empty, the head is written (rf_* = head) and popped the same cycle.
  - Minimum latency from push to write is 1 cycle.
  - The head entry's busy bit is cleared at that edge.
- x0:
  - A port-P write to x0 is dropped and counts as idle.
  - A FIFO head with addr 0 pops with rf_write_en=0; the same cycle may carry a port-P write.
- Full + push + pop in the same cycle: l_ready is 0 when full (no simultaneous push). Non-full push+pop keeps count unchanged.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and port P writes; resets to 0 on any pop or when empty.
  - On reaching STARVE_MAX, drain_stall_req is registered high for exactly one cycle, then the counter clears.
  - Contract: the cycle after the request, p_we=0. If p_we=1 anyway, port P still wins (no data loss on P).
- Scoreboard:
  - alloc_valid sets busy[alloc_rd] (ignored for rd 0).
  - A pop clears busy[head.addr].
  - Set and clear of the same rd in the same cycle: set wins.
  - busy_* reflect the registered bitmap only; no same-cycle bypass of alloc/clear.
- Reset mid-operation: FIFO contents and busy bits are discarded; no write issues in the reset cycle or the cycle it deasserts.
- Widths: count is log2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- RF_WR_BYPASS_EN defined:
  - When FIFO is empty, port P is idle and l_valid=1, the port-L result is written to the register file in the same cycle without entering the FIFO.
  - Its busy bit clears at that edge; l_ready stays 1.
- RF_WR_BYPASS_EN undefined: every port-L result passes through the FIFO (minimum 1-cycle latency).

Decomposition:
- Shared package cpu_pkg: XLEN, REG_ADDR_W=5, X0_ADDR=5'd0, typedef rf_wr_req_t {addr, data}.
- One natural sub-module: sync_fifo (parameterised depth/width, push/pop/full/empty/count), reusable elsewhere in the core.
- Arbitration, starvation counter and scoreboard stay in the top module.

Test Plan:
- Reset: assert rst mid-stream with 2 FIFO entries and busy[5]=1 -> rf_write_en=0, l_ready=0, busy_rd(5)=0, FIFO empty after release.
- Collision: p_we=1 (x3, 0xAAAA) and l push (x7, 0x1234) in the same cycle, then p_we=0 -> x3 written cycle 0; x7=0x1234 written cycle 1; busy[7] drops after cycle 1.
- Full: 5 back-to-back l pushes with p_we held 1 (FIFO_DEPTH=4) -> l_ready=0 after 4th push, 5th held; drains in order once p_we=0.
- Starvation: 1 entry queued, p_we=1 for 8 cycles -> drain_stall_req high on cycle 9 for one cycle; with p_we=0 the entry writes that cycle.
- x0 and scoreboard race: alloc_rd=9 in the same cycle as pop of x9; l entry to x0 -> busy_rd(9)=1 afterwards; x0 entry pops with rf_write_en=0.
- Bypass (RF_WR_BYPASS_EN): empty FIFO, p_we=0, l push (x4, 0x55) -> rf_write_en=1, addr 4, same cycle; without the macro, the write appears next cycle.
